imm_extend_pipe: RTL and testbench

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_extend_pipe.sv | 128 ++++++++++++
 tb/tb_imm_extend_pipe.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - immediate sign/zero/branch/prefix extension stage with one-deep output register
module imm_extend_pipe #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_prefixed,
  output logic             prefix_err
);

  // Reject parameter combinations the extension datapath cannot represent.
  generate
    if (IN_W < 2 || IN_W > 16 || OUT_W < IN_W + 1 || OUT_W > 2 * IN_W) begin : g_bad_params
      $error("imm_extend_pipe: illegal IN_W/OUT_W combination");
    end
  endgenerate

  localparam logic [1:0] MODE_SEXT   = 2'b00;
  localparam logic [1:0] MODE_ZEXT   = 2'b01;
  localparam logic [1:0] MODE_BRANCH = 2'b10;
  localparam logic [1:0] MODE_PREFIX = 2'b11;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_PREFIXED = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IN_W-1:0]  prefix_q, prefix_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             pref_q, pref_d;
  logic             err_q, err_d;

  logic             in_fire;
  logic             out_fire;
  logic             is_prefix;
  logic [OUT_W-1:0] sext_val;
  logic [OUT_W-1:0] zext_val;
  logic [OUT_W-1:0] branch_val;
  logic [OUT_W-1:0] concat_val;
  logic [OUT_W-1:0] result;

  // The output register frees up either when empty or when it is drained this cycle.
  assign in_ready  = !valid_q || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = valid_q && out_ready;
  assign is_prefix = (in_mode == MODE_PREFIX);

  assign sext_val   = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
  assign zext_val   = {{(OUT_W-IN_W){1'b0}}, in_imm};
  assign branch_val = {sext_val[OUT_W-2:0], 1'b0};
  // Prefix bits above OUT_W are simply dropped when OUT_W < 2*IN_W.
  assign concat_val = OUT_W'({prefix_q, in_imm});

  // Pick the extended value; a pending prefix overrides the mode encoding.
  always_comb begin
    result = sext_val;
    if (state_q == ST_PREFIXED) begin
      result = concat_val;
    end else begin
      case (in_mode)
        MODE_SEXT:   result = sext_val;
        MODE_ZEXT:   result = zext_val;
        MODE_BRANCH: result = branch_val;
        default:     result = sext_val;
      endcase
    end
  end

  // Next-state for the prefix FSM and the output register.
  always_comb begin
    state_d  = state_q;
    prefix_d = prefix_q;
    valid_d  = valid_q;
    data_d   = data_q;
    pref_d   = pref_q;
    err_d    = 1'b0;

    if (out_fire) begin
      valid_d = 1'b0;
    end

    if (in_fire) begin
      if (is_prefix) begin
        prefix_d = in_imm;
        state_d  = ST_PREFIXED;
        err_d    = (state_q == ST_PREFIXED);
      end else begin
        valid_d  = 1'b1;
        data_d   = result;
        pref_d   = (state_q == ST_PREFIXED);
        state_d  = ST_IDLE;
      end
    end
  end

  // State registers; reset clears everything including any pending prefix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      prefix_q <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      pref_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prefix_q <= prefix_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      pref_q   <= pref_d;
      err_q    <= err_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_data     = data_q;
  assign out_prefixed = pref_q;
  assign prefix_err   = err_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - table and scoreboard bench for imm_extend_pipe
module tb_imm_extend_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_prefixed;
  logic        prefix_err;

  imm_extend_pipe #(.IN_W(8), .OUT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_imm       (in_imm),
    .in_mode      (in_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_prefixed (out_prefixed),
    .prefix_err   (prefix_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        has_pre;
    logic [7:0]  pre;
    logic [1:0]  mode;
    logic [7:0]  imm;
    logic [15:0] exp_d;
    logic        exp_p;
  } vec_t;

  vec_t        tbl[14];
  logic [16:0] sb_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent bitwise reference for the non-prefix modes.
  function automatic logic [15:0] ref_ext(input logic [1:0] m, input logic [7:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) begin
      r[i] = (i < 8) ? v[i % 8] : ((m == 2'b01) ? 1'b0 : v[7]);
    end
    if (m == 2'b10) r = {r[14:0], 1'b0};
    return r;
  endfunction

  // Drive one input, wait for acceptance, queue the expected result.
  task automatic send(input logic [1:0] mode, input logic [7:0] imm, input bit exp_out,
                      input logic [15:0] exp_d, input logic exp_p);
    int waited = 0;
    in_mode  = mode;
    in_imm   = imm;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    if (exp_out) sb_q.push_back({exp_d, exp_p});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb_q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("drain_queue_empty", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare every output transfer against the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", out_valid, 0);
      end else begin
        logic [16:0] e;
        e = sb_q.pop_front();
        check("out_data", out_data, e[16:1]);
        check("out_prefixed", out_prefixed, e[0]);
      end
    end
  end

  initial begin
    tbl[0]  = '{1'b0, 8'h00, 2'b00, 8'h80, 16'hFF80, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 2'b00, 8'h7F, 16'h007F, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 2'b01, 8'h80, 16'h0080, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 2'b10, 8'hFE, 16'hFFFC, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 2'b10, 8'h40, 16'h0080, 1'b0};
    tbl[5]  = '{1'b1, 8'h12, 2'b00, 8'h34, 16'h1234, 1'b1};
    tbl[6]  = '{1'b0, 8'h00, 2'b00, 8'h34, 16'h0034, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 2'b01, 8'hFF, 16'h00FF, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 2'b00, 8'hFF, 16'hFFFF, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 2'b10, 8'h80, 16'hFF00, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 2'b10, 8'h7F, 16'h00FE, 1'b0};
    tbl[11] = '{1'b1, 8'hAB, 2'b10, 8'hCD, 16'hABCD, 1'b1};
    tbl[12] = '{1'b1, 8'hFF, 2'b01, 8'h00, 16'hFF00, 1'b1};
    tbl[13] = '{1'b0, 8'h00, 2'b00, 8'h00, 16'h0000, 1'b0};

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_imm    = 8'h00;
    in_mode   = 2'b00;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_prefixed", out_prefixed, 0);
    check("rst_prefix_err", prefix_err, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("post_rst_in_ready", in_ready, 1);

    // Table vectors, back to back, consumer always ready.
    foreach (tbl[i]) begin
      if (tbl[i].has_pre) begin
        send(2'b11, tbl[i].pre, 1'b0, 16'h0, 1'b0);
        check("prefix_no_output", out_valid, 0);
      end
      send(tbl[i].mode, tbl[i].imm, 1'b1, tbl[i].exp_d, tbl[i].exp_p);
    end
    idle();
    drain();
    check("valid_falls_when_drained", out_valid, 0);

    // Prefix overwritten by a prefix: one-cycle error pulse, newest prefix used.
    send(2'b11, 8'hAA, 1'b0, 16'h0, 1'b0);
    check("first_prefix_no_err", prefix_err, 0);
    send(2'b11, 8'h55, 1'b0, 16'h0, 1'b0);
    check("prefix_err_pulse", prefix_err, 1);
    idle();
    @(posedge clk);
    #1;
    check("prefix_err_one_cycle", prefix_err, 0);
    send(2'b01, 8'h01, 1'b1, 16'h5501, 1'b1);
    idle();
    drain();

    // Back-pressure: result held stable, input blocked.
    out_ready = 1'b0;
    send(2'b00, 8'h80, 1'b1, 16'hFF80, 1'b0);
    idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_out_data", out_data, 16'hFF80);
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;

    // Burst with simultaneous drain and reload; no bubble allowed.
    for (int b = 0; b < 8; b++) begin
      logic [1:0] m;
      logic [7:0] v;
      m = 2'($urandom_range(0, 2));
      v = 8'($urandom);
      send(m, v, 1'b1, ref_ext(m, v), 1'b0);
      check("burst_no_bubble", out_valid, 1);
    end
    idle();
    drain();

    // Reset while a prefixed result is held: outputs clear without a clock edge.
    send(2'b11, 8'h12, 1'b0, 16'h0, 1'b0);
    out_ready = 1'b0;
    send(2'b00, 8'h34, 1'b0, 16'h0, 1'b0);
    idle();
    check("held_prefixed_before_rst", out_prefixed, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_out_data", out_data, 0);
    check("async_rst_out_prefixed", out_prefixed, 0);
    check("async_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;

    // Reset while PREFIXED with error pulse live: prefix discarded.
    send(2'b11, 8'h12, 1'b0, 16'h0, 1'b0);
    send(2'b11, 8'h99, 1'b0, 16'h0, 1'b0);
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_prefix_err", prefix_err, 0);
    check("async_rst_valid_2", out_valid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(2'b00, 8'h34, 1'b1, 16'h0034, 1'b0);
    idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
